// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU control unit:
// state encoding, opcode constants, A-source selects and the
// control-strobe bundle with helpers that build it.
package acc_cpu_pkg;

  // FSM states; the 4-bit encoding is exported on the debug LEDs
  typedef enum logic [3:0] {
    ST_START   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC    = 4'd3,
    ST_INPUT   = 4'd4,
    ST_HALT    = 4'd5,
    ST_ILLEGAL = 4'd6,
    ST_STEP    = 4'd7
  } state_t;

  // Base opcodes (upper bit 0 when the extended set is built in)
  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_IN    = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;
  localparam logic [3:0] OP_JPOS  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  // Extended opcodes, reachable only with a 4-bit opcode field
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_NOP   = 4'h9;
  localparam logic [3:0] OP_OUT   = 4'hA;

  // A-register source selects
  localparam logic [1:0] ASEL_ADDSUB = 2'b00;
  localparam logic [1:0] ASEL_INPUT  = 2'b01;
  localparam logic [1:0] ASEL_MEM    = 2'b10;

  // Every datapath strobe the controller drives, registered as one bundle
  typedef struct packed {
    logic       irload;
    logic       jmpmux;
    logic       pcload;
    logic       meminst;
    logic       memwr;
    logic [1:0] asel;
    logic       aload;
    logic       sub;
    logic       outload;
    logic       halt;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  // Operands that come from memory and therefore honour wait states
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // 1011..1111 are unassigned in the extended set
  function automatic logic is_illegal(input logic [3:0] op);
    return op[3] && (op[2:0] > 3'd2);
  endfunction

  // Instruction fetch: address from PC, load IR, advance PC
  function automatic ctrl_t fetch_ctrl();
    ctrl_t c;
    c         = '0;
    c.irload  = 1'b1;
    c.pcload  = 1'b1;
    c.meminst = 1'b1;
    return c;
  endfunction

  // Waiting for (load=0) or taking (load=1) the operator input
  function automatic ctrl_t input_ctrl(input logic load);
    ctrl_t c;
    c            = '0;
    c.asel       = ASEL_INPUT;
    c.aload      = load;
    c.instr_done = load;
    return c;
  endfunction

  // Terminal halt, optionally flagged as caused by an unknown opcode
  function automatic ctrl_t halt_ctrl(input logic bad_op);
    ctrl_t c;
    c         = '0;
    c.halt    = 1'b1;
    c.illegal = bad_op;
    return c;
  endfunction

  // Single execute cycle for every non-waiting, non-terminal opcode
  function automatic ctrl_t exec_ctrl(input logic [3:0] op,
                                      input logic       aeq0,
                                      input logic       apos);
    ctrl_t c;
    c            = '0;
    c.instr_done = 1'b1;
    case (op)
      OP_LOAD: begin
        c.asel  = ASEL_MEM;
        c.aload = 1'b1;
      end
      OP_STORE: c.memwr = 1'b1;
      OP_ADD: begin
        c.asel  = ASEL_ADDSUB;
        c.aload = 1'b1;
      end
      OP_SUB: begin
        c.asel  = ASEL_ADDSUB;
        c.sub   = 1'b1;
        c.aload = 1'b1;
      end
      OP_JZ: begin
        c.jmpmux = aeq0;
        c.pcload = aeq0;
      end
      OP_JPOS: begin
        c.jmpmux = apos;
        c.pcload = apos;
      end
      OP_JMP: begin
        c.jmpmux = 1'b1;
        c.pcload = 1'b1;
      end
      OP_OUT:  c.outload = 1'b1;
      default: c.instr_done = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/enter_sync_edge.sv
// Enter pushbutton conditioning: two-flop synchroniser into the clock
// domain followed by an edge register. rise is a one-clock pulse on
// the clock after the synchronised level goes high.
module enter_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronise the raw button and remember the previous settled level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/acc_cpu_ctrl.sv
// Control unit for the accumulator CPU. Moore FSM that decodes the
// opcode field of IR and drives registered datapath strobes.
// Optional single-step mode: define ACC_CPU_STEP_EN to park the FSM in
// STEP after each completed instruction until the next enter press.
// Strobes are computed from the next state at each clock edge, so every
// output is glitch-free and drops to zero asynchronously on reset.
module acc_cpu_ctrl
  import acc_cpu_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int MEM_WAIT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enter,
  input  logic            Aeq0,
  input  logic            Apos,
  input  logic [OP_W-1:0] IR,
  output logic            IRload,
  output logic            JMPmux,
  output logic            PCload,
  output logic            Meminst,
  output logic            MemWr,
  output logic [1:0]      Asel,
  output logic            Aload,
  output logic            Sub,
  output logic            Outload,
  output logic            Halt,
  output logic            Illegal,
  output logic            instr_done,
  output logic [3:0]      state
);

  localparam logic [1:0] WAIT_N = 2'(MEM_WAIT);

  state_t     state_q;
  ctrl_t      ctrl_q;
  logic [1:0] wait_cnt;
  logic [3:0] op;
  logic       enter_rise;

  // A 3-bit field zero-extends onto the base half of the opcode map
  assign op = 4'(IR);

  enter_sync_edge u_enter (
    .clk   (clock),
    .rst_n (reset),
    .din   (enter),
    .rise  (enter_rise)
  );

  // Sequencer: next state plus the strobes that state will present
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_START;
      ctrl_q   <= '0;
      wait_cnt <= 2'd0;
    end else begin
      ctrl_q <= '0;
      case (state_q)
        ST_START: begin
          state_q <= ST_FETCH;
          ctrl_q  <= fetch_ctrl();
        end
        ST_FETCH: begin
          state_q  <= ST_DECODE;
          wait_cnt <= 2'd0;
        end
        ST_DECODE: begin
          if (is_mem_op(op) && (wait_cnt != WAIT_N)) begin
            wait_cnt <= wait_cnt + 2'd1;
          end else if (op == OP_IN) begin
            state_q <= ST_INPUT;
            ctrl_q  <= input_ctrl(1'b0);
          end else if (op == OP_HALT) begin
            state_q <= ST_HALT;
            ctrl_q  <= halt_ctrl(1'b0);
          end else if (is_illegal(op)) begin
            state_q <= ST_ILLEGAL;
            ctrl_q  <= halt_ctrl(1'b1);
          end else begin
            state_q <= ST_EXEC;
            ctrl_q  <= exec_ctrl(op, Aeq0, Apos);
          end
        end
        ST_INPUT: begin
          // Only an edge seen while already waiting counts as a press
          if (enter_rise) begin
            state_q <= ST_EXEC;
            ctrl_q  <= input_ctrl(1'b1);
          end else begin
            ctrl_q <= input_ctrl(1'b0);
          end
        end
        ST_EXEC: begin
`ifdef ACC_CPU_STEP_EN
          state_q <= ST_STEP;
`else
          state_q <= ST_FETCH;
          ctrl_q  <= fetch_ctrl();
`endif
        end
`ifdef ACC_CPU_STEP_EN
        ST_STEP: begin
          if (enter_rise) begin
            state_q <= ST_FETCH;
            ctrl_q  <= fetch_ctrl();
          end
        end
`endif
        ST_HALT:    ctrl_q <= halt_ctrl(1'b0);
        ST_ILLEGAL: ctrl_q <= halt_ctrl(1'b1);
        default:    state_q <= ST_START;
      endcase
    end
  end

  assign IRload     = ctrl_q.irload;
  assign JMPmux     = ctrl_q.jmpmux;
  assign PCload     = ctrl_q.pcload;
  assign Meminst    = ctrl_q.meminst;
  assign MemWr      = ctrl_q.memwr;
  assign Asel       = ctrl_q.asel;
  assign Aload      = ctrl_q.aload;
  assign Sub        = ctrl_q.sub;
  assign Outload    = ctrl_q.outload;
  assign Halt       = ctrl_q.halt;
  assign Illegal    = ctrl_q.illegal;
  assign instr_done = ctrl_q.instr_done;
  assign state      = state_q;

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Bench for acc_cpu_ctrl built with OP_W=4, MEM_WAIT=2. Expected
// per-cycle output vectors {state, strobes} are queued as each
// instruction is driven and compared one per clock, 1ns after the edge.
module tb_acc_cpu_ctrl;
  import acc_cpu_pkg::*;

  localparam int OP_W     = 4;
  localparam int MEM_WAIT = 2;
  localparam int VW       = 17;

  // Strobe patterns: IRload JMPmux PCload Meminst MemWr Asel[1:0] Aload Sub Outload Halt Illegal instr_done
  localparam logic [12:0] B_NONE  = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] B_FETCH = 13'b1_0_1_1_0_00_0_0_0_0_0_0;
  localparam logic [12:0] B_LOAD  = 13'b0_0_0_0_0_10_1_0_0_0_0_1;
  localparam logic [12:0] B_STORE = 13'b0_0_0_0_1_00_0_0_0_0_0_1;
  localparam logic [12:0] B_ADD   = 13'b0_0_0_0_0_00_1_0_0_0_0_1;
  localparam logic [12:0] B_SUB   = 13'b0_0_0_0_0_00_1_1_0_0_0_1;
  localparam logic [12:0] B_JMP   = 13'b0_1_1_0_0_00_0_0_0_0_0_1;
  localparam logic [12:0] B_DONE  = 13'b0_0_0_0_0_00_0_0_0_0_0_1;
  localparam logic [12:0] B_OUT   = 13'b0_0_0_0_0_00_0_0_1_0_0_1;
  localparam logic [12:0] B_INW   = 13'b0_0_0_0_0_01_0_0_0_0_0_0;
  localparam logic [12:0] B_INL   = 13'b0_0_0_0_0_01_1_0_0_0_0_1;
  localparam logic [12:0] B_HALT  = 13'b0_0_0_0_0_00_0_0_0_1_0_0;
  localparam logic [12:0] B_ILL   = 13'b0_0_0_0_0_00_0_0_0_1_1_0;

  logic            clock = 1'b0;
  logic            reset;
  logic            enter;
  logic            Aeq0;
  logic            Apos;
  logic [OP_W-1:0] IR;
  logic            IRload, JMPmux, PCload, Meminst, MemWr;
  logic [1:0]      Asel;
  logic            Aload, Sub, Outload, Halt, Illegal, instr_done;
  logic [3:0]      state;

  logic [VW-1:0] exp_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            aload_seen  = 0;
  string         cur_tag     = "init";

  // Clock and reset
  always #5 clock = ~clock;

  acc_cpu_ctrl #(.OP_W(OP_W), .MEM_WAIT(MEM_WAIT)) dut (
    .clock      (clock),
    .reset      (reset),
    .enter      (enter),
    .Aeq0       (Aeq0),
    .Apos       (Apos),
    .IR         (IR),
    .IRload     (IRload),
    .JMPmux     (JMPmux),
    .PCload     (PCload),
    .Meminst    (Meminst),
    .MemWr      (MemWr),
    .Asel       (Asel),
    .Aload      (Aload),
    .Sub        (Sub),
    .Outload    (Outload),
    .Halt       (Halt),
    .Illegal    (Illegal),
    .instr_done (instr_done),
    .state      (state)
  );

  wire [VW-1:0] obs = {state, IRload, JMPmux, PCload, Meminst, MemWr, Asel,
                       Aload, Sub, Outload, Halt, Illegal, instr_done};

  // Scoreboard
  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: observed %h, expected %h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [3:0] st, input logic [12:0] s);
    exp_q.push_back({st, s});
  endtask

  task automatic check_now();
    if (exp_q.size() > 0) check_vec(cur_tag, 32'(obs), 32'(exp_q.pop_front()));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (Aload) aload_seen++;
    check_now();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

  // Reference execute-cycle strobes
  function automatic logic [12:0] exec_bits(input logic [3:0] op, input logic a0, input logic ap);
    case (op)
      4'h0:    return B_LOAD;
      4'h1:    return B_STORE;
      4'h2:    return B_ADD;
      4'h3:    return B_SUB;
      4'h5:    return a0 ? B_JMP : B_DONE;
      4'h6:    return ap ? B_JMP : B_DONE;
      4'h8:    return B_JMP;
      4'h9:    return B_DONE;
      4'hA:    return B_OUT;
      default: return B_NONE;
    endcase
  endfunction

  // Driver tasks
  // Wait in STEP for a few clocks, then a press advances to FETCH
  task automatic step_press();
    repeat (3) push_exp(ST_STEP, B_NONE);
    drain();
    enter = 1'b1;
    push_exp(ST_STEP, B_NONE);
    push_exp(ST_STEP, B_NONE);
    push_exp(ST_FETCH, B_FETCH);
    drain();
    enter = 1'b0;
  endtask

  task automatic tail();
`ifdef ACC_CPU_STEP_EN
    push_exp(ST_STEP, B_NONE);
    drain();
    step_press();
`else
    push_exp(ST_FETCH, B_FETCH);
    drain();
`endif
  endtask

  // Starts with the DUT in FETCH; optional enter press during DECODE
  task automatic do_instr(input string tag, input logic [3:0] op,
                          input logic a0, input logic ap, input logic press);
    int n;
    cur_tag = tag;
    IR      = op;
    Aeq0    = a0;
    Apos    = ap;
    n = (op == 4'h0 || op == 4'h2 || op == 4'h3) ? 1 + MEM_WAIT : 1;
    for (int i = 0; i < n; i++) push_exp(ST_DECODE, B_NONE);
    push_exp(ST_EXEC, exec_bits(op, a0, ap));
    for (int i = 0; i < n + 1; i++) begin
      if (press && i == 1) enter = 1'b1;
      if (press && i == 3) enter = 1'b0;
      tick();
    end
    tail();
  endtask

  // Asynchronous reset held across one edge, released at a falling edge
  task automatic reset_mid(input string tag);
    cur_tag = tag;
    reset = 1'b0;
    #2;
    push_exp(ST_START, B_NONE);
    check_now();
    @(posedge clock);
    #1;
    push_exp(ST_START, B_NONE);
    check_now();
    @(negedge clock);
    reset = 1'b1;
    push_exp(ST_FETCH, B_FETCH);
    drain();
  endtask

  task automatic do_term(input string tag, input logic [3:0] op,
                         input logic [3:0] st, input logic [12:0] bits);
    cur_tag = tag;
    IR = op;
    push_exp(ST_DECODE, B_NONE);
    repeat (4) push_exp(st, bits);
    drain();
    reset_mid({tag, "_reset"});
  endtask

  task automatic do_input();
    cur_tag = "in";
    IR = 4'h4;
    push_exp(ST_DECODE, B_NONE);
    repeat (3) push_exp(ST_INPUT, B_INW);
    drain();
    aload_seen = 0;
    enter = 1'b1;
    push_exp(ST_INPUT, B_INW);
    push_exp(ST_INPUT, B_INW);
    push_exp(ST_EXEC, B_INL);
`ifdef ACC_CPU_STEP_EN
    repeat (7) push_exp(ST_STEP, B_NONE);
`else
    push_exp(ST_FETCH, B_FETCH);
    push_exp(ST_DECODE, B_NONE);
    repeat (5) push_exp(ST_INPUT, B_INW);
`endif
    drain();
    enter = 1'b0;
    check_vec("in_single_load", 32'(aload_seen), 32'd1);
`ifdef ACC_CPU_STEP_EN
    step_press();
`else
    cur_tag = "in_second_press";
    repeat (3) push_exp(ST_INPUT, B_INW);
    drain();
    enter = 1'b1;
    push_exp(ST_INPUT, B_INW);
    push_exp(ST_INPUT, B_INW);
    push_exp(ST_EXEC, B_INL);
    push_exp(ST_FETCH, B_FETCH);
    drain();
    enter = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b0;
    enter = 1'b0;
    IR    = '0;
    Aeq0  = 1'b0;
    Apos  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cur_tag = "reset";
    push_exp(ST_START, B_NONE);
    check_now();
    @(negedge clock);
    reset = 1'b1;
    cur_tag = "first_fetch";
    push_exp(ST_FETCH, B_FETCH);
    drain();

    reset_mid("reset_mid_fetch");

    do_instr("load",      4'h0, 1'b0, 1'b0, 1'b0);
    do_instr("store",     4'h1, 1'b0, 1'b0, 1'b0);
    do_instr("add",       4'h2, 1'b0, 1'b1, 1'b0);
    do_instr("sub",       4'h3, 1'b1, 1'b0, 1'b0);
    do_instr("jz_taken",  4'h5, 1'b1, 1'b0, 1'b0);
    do_instr("jz_not",    4'h5, 1'b0, 1'b1, 1'b0);
    do_instr("jpos_not",  4'h6, 1'b1, 1'b0, 1'b0);
    do_instr("jpos_take", 4'h6, 1'b0, 1'b1, 1'b0);
    do_instr("jmp",       4'h8, 1'b0, 1'b0, 1'b0);
    do_instr("nop",       4'h9, 1'b0, 1'b0, 1'b0);
    do_instr("out",       4'hA, 1'b0, 1'b0, 1'b0);
    do_instr("add_early_press", 4'h2, 1'b0, 1'b0, 1'b1);
    do_input();

    for (int k = 0; k < 4; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 3));
      do_instr("rand_alu", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    cur_tag = "store_reset";
    IR = 4'h1;
    push_exp(ST_DECODE, B_NONE);
    push_exp(ST_EXEC, B_STORE);
    drain();
    reset_mid("store_reset");

    do_term("illegal_c", 4'hC, ST_ILLEGAL, B_ILL);
    do_term("illegal_b", 4'hB, ST_ILLEGAL, B_ILL);
    do_term("halt",      4'h7, ST_HALT,    B_HALT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
